// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending sequencer: coin credit, product vend with timeout refund, coin change
module vend_sequencer #(
  parameter int PRICE0     = 15,
  parameter int PRICE1     = 20,
  parameter int PRICE2     = 25,
  parameter int PRICE3     = 30,
  parameter int MAX_CREDIT = 95,
  parameter int TIMEOUT    = 1000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       coin_pulse,
  input  logic       coin_val,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  output logic       disp_req,
  output logic [1:0] disp_slot,
  input  logic       disp_ack,
  output logic       chg_req,
  output logic       chg_coin,
  input  logic       chg_ack,
  output logic [6:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       sel_short,
  output logic       vend_done,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  state_t     state;
  logic [9:0] wait_cnt;
  logic [6:0] vend_price;
  logic [6:0] sel_price;
  logic [7:0] coin_sum;
  logic [6:0] chg_amount;

  always_comb begin
    sel_price = 7'(PRICE0);
    case (sel_id)
      2'd0: sel_price = 7'(PRICE0);
      2'd1: sel_price = 7'(PRICE1);
      2'd2: sel_price = 7'(PRICE2);
      2'd3: sel_price = 7'(PRICE3);
      default: sel_price = 7'(PRICE0);
    endcase
  end

  assign coin_sum   = {1'b0, credit} + (coin_val ? 8'd10 : 8'd5);
  assign chg_amount = chg_coin ? 7'd10 : 7'd5;
  assign busy       = (state != IDLE);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= 7'd0;
      disp_req    <= 1'b0;
      disp_slot   <= 2'd0;
      chg_req     <= 1'b0;
      chg_coin    <= 1'b0;
      coin_reject <= 1'b0;
      sel_short   <= 1'b0;
      vend_done   <= 1'b0;
      fault       <= 1'b0;
      wait_cnt    <= 10'd0;
      vend_price  <= 7'd0;
    end else begin
      coin_reject <= 1'b0;
      sel_short   <= 1'b0;
      vend_done   <= 1'b0;
      fault       <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel) begin
            // A coin arriving alongside cancel or a selection always loses.
            coin_reject <= coin_pulse;
            if (credit != 7'd0) state <= CHANGE;
          end else if (sel_valid) begin
            coin_reject <= coin_pulse;
            if (credit >= sel_price) begin
              credit     <= credit - sel_price;
              disp_slot  <= sel_id;
              disp_req   <= 1'b1;
              vend_price <= sel_price;
              wait_cnt   <= 10'd0;
              state      <= VEND;
            end else begin
              sel_short <= 1'b1;
            end
          end else if (coin_pulse) begin
            if (coin_sum <= 8'(MAX_CREDIT)) credit <= coin_sum[6:0];
            else coin_reject <= 1'b1;
          end
        end
        VEND: begin
          coin_reject <= coin_pulse;
          if (disp_ack) begin
            disp_req  <= 1'b0;
            vend_done <= 1'b1;
            state     <= (credit != 7'd0) ? CHANGE : IDLE;
          end else if (wait_cnt == 10'(TIMEOUT - 1)) begin
            credit   <= credit + vend_price;
            disp_req <= 1'b0;
            fault    <= 1'b1;
            state    <= CHANGE;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        CHANGE: begin
          coin_reject <= coin_pulse;
          // chg_req low for a cycle between coins falls out of raising only from low.
          if (!chg_req) begin
            chg_req  <= 1'b1;
            chg_coin <= (credit >= 7'd10);
          end else if (chg_ack) begin
            chg_req <= 1'b0;
            credit  <= credit - chg_amount;
            if (credit == chg_amount) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed self-checking bench for vend_sequencer
module tb_vend_sequencer;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_pulse = 1'b0;
  logic       coin_val = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       disp_req;
  logic [1:0] disp_slot;
  logic       disp_ack = 1'b0;
  logic       chg_req;
  logic       chg_coin;
  logic       chg_ack = 1'b0;
  logic [6:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       sel_short;
  logic       vend_done;
  logic       fault;

  int checks = 0;
  int errors = 0;

  vend_sequencer dut (
    .sys_clk(sys_clk), .reset(reset), .coin_pulse(coin_pulse), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .disp_req(disp_req), .disp_slot(disp_slot), .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_coin(chg_coin), .chg_ack(chg_ack),
    .credit(credit), .busy(busy), .coin_reject(coin_reject),
    .sel_short(sel_short), .vend_done(vend_done), .fault(fault)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic coin(input logic ten);
    coin_pulse = 1'b1;
    coin_val = ten;
    tick();
    coin_pulse = 1'b0;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1;
    sel_id = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic change_coin(input logic exp_coin);
    int n = 0;
    while (!chg_req && n < 8) begin
      tick();
      n++;
    end
    check("chg_req_up", chg_req, 1);
    check("chg_coin", chg_coin, exp_coin);
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    check("chg_req_drop", chg_req, 0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_credit", credit, 0);
    check("rst_disp_req", disp_req, 0);
    check("rst_chg_req", chg_req, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {coin_reject, sel_short, vend_done, fault}, 0);
    reset = 1'b0;

    // Coins 10,5 then slot 0
    coin(1'b1);
    check("c039_credit10", credit, 10);
    coin(1'b0);
    check("c039_credit15", credit, 15);
    select(2'd0);
    check("c039_credit0", credit, 0);
    check("c039_disp_req", disp_req, 1);
    check("c039_disp_slot", disp_slot, 0);
    check("c039_busy", busy, 1);
    coin(1'b1);
    check("vend_coin_reject", coin_reject, 1);
    check("vend_coin_credit", credit, 0);
    tick();
    check("c039_disp_hold", disp_req, 1);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    check("c039_disp_drop", disp_req, 0);
    check("c039_vend_done", vend_done, 1);
    check("c039_idle", busy, 0);
    tick();
    check("c039_done_width", vend_done, 0);

    // Coins 10,10,10 then slot 1 with change of 10
    coin(1'b1); coin(1'b1); coin(1'b1);
    check("c040_credit30", credit, 30);
    select(2'd1);
    check("c040_credit10", credit, 10);
    check("c040_slot", disp_slot, 1);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    check("c040_vend_done", vend_done, 1);
    check("c040_busy", busy, 1);
    change_coin(1'b1);
    check("c040_credit0", credit, 0);
    check("c040_idle", busy, 0);

    // Short selection and ceiling rejection
    coin(1'b0);
    select(2'd3);
    check("c041_sel_short", sel_short, 1);
    check("c041_credit5", credit, 5);
    check("c041_no_vend", disp_req, 0);
    for (int i = 0; i < 8; i++) coin(1'b1);
    coin(1'b0);
    check("c041_credit90", credit, 90);
    coin(1'b1);
    check("c041_coin_reject", coin_reject, 1);
    check("c041_credit_hold", credit, 90);
    coin(1'b0);
    check("c041_credit95", credit, 95);
    check("c041_accept_no_reject", coin_reject, 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("c041_cancel_busy", busy, 1);
    for (int i = 0; i < 9; i++) change_coin(1'b1);
    change_coin(1'b0);
    check("c041_drain_credit", credit, 0);
    check("c041_drain_idle", busy, 0);

    // Dispense timeout refund
    coin(1'b1); coin(1'b1); coin(1'b0);
    select(2'd2);
    check("c042_credit0", credit, 0);
    for (int i = 0; i < 999; i++) tick();
    check("c042_no_fault_yet", fault, 0);
    check("c042_still_req", disp_req, 1);
    tick();
    check("c042_fault", fault, 1);
    check("c042_refund", credit, 25);
    check("c042_disp_drop", disp_req, 0);
    check("c042_busy", busy, 1);
    change_coin(1'b1);
    change_coin(1'b1);
    change_coin(1'b0);
    check("c042_credit0_end", credit, 0);
    check("c042_idle", busy, 0);

    // Same-cycle cancel, selection and coin
    coin(1'b1); coin(1'b0);
    cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0; coin_pulse = 1'b1; coin_val = 1'b1;
    tick();
    cancel = 1'b0; sel_valid = 1'b0; coin_pulse = 1'b0;
    check("c043_coin_reject", coin_reject, 1);
    check("c043_no_vend", disp_req, 0);
    check("c043_credit", credit, 15);
    check("c043_busy", busy, 1);
    change_coin(1'b1);
    change_coin(1'b0);
    check("c043_idle", busy, 0);

    // Reset during change
    coin(1'b1); coin(1'b1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    check("c044_chg_req_up", chg_req, 1);
    check("c044_credit20", credit, 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("c044_credit0", credit, 0);
    check("c044_chg_req0", chg_req, 0);
    check("c044_busy0", busy, 0);
    coin(1'b0);
    check("first_coin_after_reset", credit, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
